adc_scan_scheduler: RTL and testbench

Sequencer that owns the ADC128S102 serial driver and shares it between a background round-robin channel scan and on-demand single-channel requests. Issues one-cycle conversion starts with a held channel address, tracks the ADC's one-frame address pipeline to tag each returned sample with its true channel, and keeps a per-channel result table. Sits between user logic and the driver (`adc_conv_go`/`adc_addr` out, `adc_conv_done`/`adc_data` in).

---
 rtl/adc_sched_pkg.sv | 25 ++
 rtl/adc_scan_scheduler_rr_pick.sv | 27 ++
 rtl/adc_scan_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared types, sizes and the EMA helper for the ADC scan scheduler
package adc_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int ADC_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } state_e;

    // old + ((new - old) >>> 2), one extra bit so the difference keeps its sign
    function automatic logic [ADC_W-1:0] ema_update(input logic [ADC_W-1:0] old_v,
                                                    input logic [ADC_W-1:0] new_v);
        logic signed [ADC_W:0] diff;
        logic signed [ADC_W:0] sum;
        diff = $signed({1'b0, new_v}) - $signed({1'b0, old_v});
        sum  = $signed({1'b0, old_v}) + (diff >>> 2);
        return sum[ADC_W-1:0];
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_rr_pick.sv
// rtl/adc_scan_scheduler_rr_pick.sv - next enabled channel strictly after the last one, wrapping
module adc_rr_pick
    import adc_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   last_i,
    output logic [CH_W-1:0]   next_o,
    output logic              any_o
);

    logic [CH_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest enabled one wins.
    always_comb begin
        next_o = last_i;
        cand   = last_i;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = last_i + CH_W'(k);
            if (mask_i[cand]) begin
                next_o = cand;
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - ADC frame sequencer: round-robin scan, single requests, result table
// ADC_SCHED_AVG_EN: table holds a per-channel EMA instead of the raw sample.
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int FRAME_TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scan_en_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [CH_W-1:0]   req_ch_i,
    output logic              rsp_valid_o,
    output logic [ADC_W-1:0]  rsp_data_o,
    output logic              adc_conv_go_o,
    output logic [CH_W-1:0]   adc_addr_o,
    input  logic              adc_conv_done_i,
    input  logic [ADC_W-1:0]  adc_data_i,
    output logic              res_valid_o,
    output logic [CH_W-1:0]   res_ch_o,
    output logic [ADC_W-1:0]  res_data_o,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [ADC_W-1:0]  rd_data_o,
    output logic              busy_o,
    output logic              timeout_err_o
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_e           state_q;
    logic             go_q;
    logic [CH_W-1:0]  addr_q;
    logic             cur_req_q;
    logic [CH_W-1:0]  prev_addr_q;
    logic             prev_req_q;
    logic             primed_q;
    logic             pend_q;
    logic [CH_W-1:0]  pend_ch_q;
    logic             issued_q;
    logic             owe_q;
    logic [CH_W-1:0]  last_q;
    logic [TW-1:0]    wait_cnt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             res_valid_q;
    logic [CH_W-1:0]  res_ch_q;
    logic [ADC_W-1:0] res_data_q;
    logic             rsp_valid_q;
    logic [ADC_W-1:0] rsp_data_q;
    logic             tmo_q;
    logic [ADC_W-1:0] tbl_q [NUM_CH];
    logic [ADC_W-1:0] rd_data_q;
`ifdef ADC_SCHED_AVG_EN
    logic [NUM_CH-1:0] seen_q;
`endif

    logic             done_d;
    logic             tmo_d;
    logic             wr_en_d;
    logic [ADC_W-1:0] wr_data_d;
    logic [CH_W-1:0]  rr_next;
    logic             rr_any;

    adc_rr_pick u_rr_pick (
        .mask_i (ch_mask_i),
        .last_i (last_q),
        .next_o (rr_next),
        .any_o  (rr_any)
    );

    always_comb begin
        done_d    = (state_q == ST_WAIT) && adc_conv_done_i;
        tmo_d     = (state_q == ST_WAIT) && !adc_conv_done_i
                    && (wait_cnt_q == TW'(FRAME_TIMEOUT - 1));
        wr_en_d   = done_d && primed_q;
        wr_data_d = adc_data_i;
`ifdef ADC_SCHED_AVG_EN
        if (seen_q[prev_addr_q]) begin
            wr_data_d = ema_update(tbl_q[prev_addr_q], adc_data_i);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            go_q        <= 1'b0;
            addr_q      <= '0;
            cur_req_q   <= 1'b0;
            prev_addr_q <= '0;
            prev_req_q  <= 1'b0;
            primed_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_ch_q   <= '0;
            issued_q    <= 1'b0;
            owe_q       <= 1'b0;
            last_q      <= CH_W'(NUM_CH - 1);
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tmo_q       <= 1'b0;
        end else begin
            go_q        <= 1'b0;
            res_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            tmo_q       <= 1'b0;

            if (req_valid_i && !pend_q) begin
                pend_q    <= 1'b1;
                pend_ch_q <= req_ch_i;
            end

            case (state_q)
                ST_IDLE: begin
                    // issued_q keeps an in-flight request from being re-issued by its follow-up decision
                    if (pend_q && !issued_q) begin
                        addr_q    <= pend_ch_q;
                        cur_req_q <= 1'b1;
                        issued_q  <= 1'b1;
                        owe_q     <= 1'b1;
                        go_q      <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else if (owe_q) begin
                        cur_req_q <= 1'b0;
                        owe_q     <= 1'b0;
                        go_q      <= 1'b1;
                        state_q   <= ST_ISSUE;
                        if (scan_en_i && rr_any) begin
                            addr_q <= rr_next;
                            last_q <= rr_next;
                        end else begin
                            addr_q <= pend_ch_q;
                        end
                    end else if (scan_en_i && rr_any) begin
                        addr_q    <= rr_next;
                        last_q    <= rr_next;
                        cur_req_q <= 1'b0;
                        go_q      <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_d) begin
                        // The returned sample belongs to the previous frame's address.
                        if (primed_q) begin
                            res_valid_q <= 1'b1;
                            res_ch_q    <= prev_addr_q;
                            res_data_q  <= adc_data_i;
                            if (prev_req_q) begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= adc_data_i;
                                pend_q      <= 1'b0;
                                issued_q    <= 1'b0;
                            end
                        end
                        prev_addr_q <= addr_q;
                        prev_req_q  <= cur_req_q;
                        primed_q    <= 1'b1;
                        gap_cnt_q   <= '0;
                        state_q     <= ST_GAP;
                    end else if (tmo_d) begin
                        tmo_q      <= 1'b1;
                        primed_q   <= 1'b0;
                        prev_req_q <= 1'b0;
                        issued_q   <= 1'b0;
                        gap_cnt_q  <= '0;
                        state_q    <= ST_GAP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tbl_q[i] <= '0;
            end
            rd_data_q <= '0;
`ifdef ADC_SCHED_AVG_EN
            seen_q    <= '0;
`endif
        end else begin
            if (wr_en_d) begin
                tbl_q[prev_addr_q] <= wr_data_d;
            end
            rd_data_q <= tbl_q[rd_ch_i];
`ifdef ADC_SCHED_AVG_EN
            if (tmo_d) begin
                seen_q <= '0;
            end else if (wr_en_d) begin
                seen_q[prev_addr_q] <= 1'b1;
            end
`endif
        end
    end

    assign req_ready_o   = ~pend_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign adc_conv_go_o = go_q;
    assign adc_addr_o    = addr_q;
    assign res_valid_o   = res_valid_q;
    assign res_ch_o      = res_ch_q;
    assign res_data_o    = res_data_q;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = (state_q != ST_IDLE) || pend_q;
    assign timeout_err_o = tmo_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb/tb_adc_scan_scheduler.sv - self-checking bench: ADC driver model, result/response scoreboards
module tb_adc_scan_scheduler;
    import adc_sched_pkg::*;

    localparam int GAP = 16;
    localparam int FT  = 1023;
    localparam int LAT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              scan_en_i = 1'b0;
    logic [NUM_CH-1:0] ch_mask_i = '0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [CH_W-1:0]   req_ch_i = '0;
    logic              rsp_valid_o;
    logic [ADC_W-1:0]  rsp_data_o;
    logic              adc_conv_go_o;
    logic [CH_W-1:0]   adc_addr_o;
    logic              adc_conv_done_i = 1'b0;
    logic [ADC_W-1:0]  adc_data_i = '0;
    logic              res_valid_o;
    logic [CH_W-1:0]   res_ch_o;
    logic [ADC_W-1:0]  res_data_o;
    logic [CH_W-1:0]   rd_ch_i = '0;
    logic [ADC_W-1:0]  rd_data_o;
    logic              busy_o;
    logic              timeout_err_o;

    adc_scan_scheduler #(.GAP_CYCLES(GAP), .FRAME_TIMEOUT(FT)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .scan_en_i       (scan_en_i),
        .ch_mask_i       (ch_mask_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_ch_i        (req_ch_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .adc_conv_go_o   (adc_conv_go_o),
        .adc_addr_o      (adc_addr_o),
        .adc_conv_done_i (adc_conv_done_i),
        .adc_data_i      (adc_data_i),
        .res_valid_o     (res_valid_o),
        .res_ch_o        (res_ch_o),
        .res_data_o      (res_data_o),
        .rd_ch_i         (rd_ch_i),
        .rd_data_o       (rd_data_o),
        .busy_o          (busy_o),
        .timeout_err_o   (timeout_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [ADC_W-1:0] data;
    } res_t;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [ADC_W-1:0] exp;
    } rd_vec_t;

    int errors = 0;
    int checks = 0;

    res_t             res_q[$];
    logic [ADC_W-1:0] rsp_q[$];
    logic [CH_W-1:0]  go_q[$];
    logic [ADC_W-1:0] chan_val[NUM_CH];
    res_t             mon_r;
    logic [ADC_W-1:0] mon_rsp;

    int go_cnt = 0, res_cnt = 0, rsp_cnt = 0, tmo_cnt = 0, res1_cnt = 0;
    int cyc = 0, last_go_cyc = 0, tmo_cyc = 0;
    logic [ADC_W-1:0] last_res1_data = '0;

    int              drv_cnt = 0;
    bit              drv_hang = 1'b0;
    bit              drv_stale = 1'b0;
    logic [CH_W-1:0] drv_frame_addr = '0;
    logic [CH_W-1:0] adc_last = '0;
    logic [CH_W-1:0] tb_prev = '0;
    bit              tb_primed = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor + ADC driver model; the ADC returns the sample addressed in the previous frame.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (res_valid_o) begin
                res_cnt++;
                if (res_ch_o == 3'd1) begin
                    res1_cnt++;
                    last_res1_data = res_data_o;
                end
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL res_unexpected actual=ch%0d/%0h required=none", res_ch_o, res_data_o);
                end else begin
                    mon_r = res_q.pop_front();
                    checks--;
                    chk("res_ch", res_ch_o, mon_r.ch);
                    chk("res_data", res_data_o, mon_r.data);
                end
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected actual=%0h required=none", rsp_data_o);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    checks--;
                    chk("rsp_data", rsp_data_o, mon_rsp);
                end
            end
            if (timeout_err_o) begin
                tmo_cnt++;
                tmo_cyc   = cyc;
                tb_primed = 1'b0;
            end
            if (adc_conv_go_o) begin
                go_q.push_back(adc_addr_o);
                go_cnt++;
                last_go_cyc    = cyc;
                drv_frame_addr = adc_addr_o;
                drv_stale      = 1'b0;
                if (!drv_hang) drv_cnt = LAT;
            end
            adc_conv_done_i = 1'b0;
            if (drv_cnt > 0) begin
                drv_cnt--;
                if (drv_cnt == 0) begin
                    adc_conv_done_i = 1'b1;
                    adc_data_i      = chan_val[adc_last];
                    if (!drv_stale) begin
                        if (tb_primed) begin
                            mon_r.ch   = tb_prev;
                            mon_r.data = chan_val[tb_prev];
                            res_q.push_back(mon_r);
                        end
                        tb_prev   = drv_frame_addr;
                        tb_primed = 1'b1;
                    end
                    adc_last = drv_frame_addr;
                end
            end
        end
    end

    task automatic wait_go(input int n, input string name);
        int target = go_cnt + n;
        int t = 0;
        while (go_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(go_cnt >= target), 1);
    endtask

    task automatic wait_rsp(input int base, input string name);
        int t = 0;
        while (rsp_cnt <= base && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(rsp_cnt > base), 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_o || drv_cnt != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(!busy_o), 1);
    endtask

    task automatic send_req(input logic [CH_W-1:0] ch);
        rsp_q.push_back(chan_val[ch]);
        req_ch_i    = ch;
        req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    rd_vec_t rv[NUM_CH];

    initial begin
        int base_go, base_rsp, base_res, qidx, t;
        bit early;
        logic [CH_W-1:0] last_scan, exp_next;

        for (int i = 0; i < NUM_CH; i++) chan_val[i] = 12'h100 + ADC_W'(i);
        for (int i = 0; i < NUM_CH; i++) begin
            rv[i].ch  = CH_W'(i);
            rv[i].exp = '0;
        end
        rv[0].exp = 12'h100;
        rv[2].exp = 12'h102;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_go", adc_conv_go_o, 0);
        chk("rst_addr", adc_addr_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_err_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        rst = 1'b0;

        // Scan mask 0x05: frames 0,2,0,2
        scan_en_i = 1'b1;
        ch_mask_i = 8'h05;
        wait_go(4, "t1_four_frames");
        if (go_q.size() >= 4) begin
            chk("t1_addr0", go_q[0], 0);
            chk("t1_addr1", go_q[1], 2);
            chk("t1_addr2", go_q[2], 0);
            chk("t1_addr3", go_q[3], 2);
        end
        scan_en_i = 1'b0;
        wait_idle("t1_idle");
        chk("t1_res_count_ok", int'(res_cnt >= 3), 1);
        chk("t1_res_drained", res_q.size(), 0);

        for (int i = 0; i < NUM_CH; i++) begin
            rd_ch_i = rv[i].ch;
            @(negedge clk);
            chk($sformatf("t1_table_ch%0d", i), rd_data_o, rv[i].exp);
        end

        // Single request ch5, scan off: frames 5,5, one response
        base_go  = go_cnt;
        base_rsp = rsp_cnt;
        qidx     = go_q.size();
        send_req(3'd5);
        chk("t2_ready_low", req_ready_o, 0);
        early = 1'b0;
        t = 0;
        while (rsp_cnt <= base_rsp && t < 3000) begin
            if (req_ready_o && !rsp_valid_o && rsp_cnt == base_rsp) early = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("t2_rsp_seen", int'(rsp_cnt > base_rsp), 1);
        chk("t2_ready_held_low", early, 0);
        chk("t2_ready_after", req_ready_o, 1);
        wait_idle("t2_idle");
        chk("t2_frames", go_cnt - base_go, 2);
        if (go_q.size() >= qidx + 2) begin
            chk("t2_addr0", go_q[qidx], 5);
            chk("t2_addr1", go_q[qidx+1], 5);
        end
        chk("t2_one_rsp", rsp_cnt - base_rsp, 1);

        // Request ch3 preempts an 0xFF scan; scan resumes after the last scanned channel
        scan_en_i = 1'b1;
        ch_mask_i = 8'hFF;
        wait_go(2, "t3_scan_started");
        last_scan = go_q[go_q.size()-1];
        exp_next  = last_scan + 3'd1;
        qidx      = go_q.size();
        base_rsp  = rsp_cnt;
        send_req(3'd3);
        wait_go(2, "t3_frames");
        if (go_q.size() >= qidx + 2) begin
            chk("t3_req_frame", go_q[qidx], 3);
            chk("t3_resume", go_q[qidx+1], exp_next);
        end
        wait_rsp(base_rsp, "t3_rsp_seen");
        scan_en_i = 1'b0;
        wait_idle("t3_idle");
        chk("t3_rsp_drained", rsp_q.size(), 0);

        // Hung frame: timeout pulse, then prime frame, then answered re-issue
        drv_hang = 1'b1;
        base_rsp = rsp_cnt;
        send_req(3'd6);
        t = 0;
        while (tmo_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        drv_hang = 1'b0;
        chk("t4_timeout_seen", tmo_cnt, 1);
        chk("t4_timeout_cycles", tmo_cyc - last_go_cyc, FT + 1);
        base_res = res_cnt;
        qidx     = go_q.size();
        @(negedge clk);
        chk("t4_timeout_one_cycle", timeout_err_o, 0);
        wait_go(2, "t4_reissue_frames");
        chk("t4_prime_no_res", res_cnt - base_res, 0);
        if (go_q.size() >= qidx + 1) chk("t4_reissue_addr", go_q[qidx], 6);
        wait_rsp(base_rsp, "t4_rsp_seen");
        wait_idle("t4_idle");

        // Reset mid-WAIT: outputs clear, late done ignored, fresh prime frame
        scan_en_i = 1'b1;
        ch_mask_i = 8'h05;
        wait_go(1, "t5_frame");
        @(negedge clk);
        rst       = 1'b1;
        scan_en_i = 1'b0;
        tb_primed = 1'b0;
        drv_stale = 1'b1;
        res_q.delete();
        rsp_q.delete();
        #1;
        chk("t5_go", adc_conv_go_o, 0);
        chk("t5_addr", adc_addr_o, 0);
        chk("t5_res_valid", res_valid_o, 0);
        chk("t5_busy", busy_o, 0);
        chk("t5_rd_data", rd_data_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        base_res = res_cnt;
        repeat (LAT + 4) @(negedge clk);
        chk("t5_late_done_ignored", res_cnt - base_res, 0);
        chk("t5_still_idle", busy_o, 0);
        rd_ch_i = 3'd0;
        @(negedge clk);
        chk("t5_table_cleared", rd_data_o, 0);
        qidx      = go_q.size();
        scan_en_i = 1'b1;
        wait_go(2, "t5_restart");
        if (go_q.size() >= qidx + 1) chk("t5_first_addr", go_q[qidx], 0);
        chk("t5_prime_no_res", res_cnt - base_res, 0);

        // Channel 1 samples 400 then 800: table raw or EMA
        chan_val[1] = 12'd400;
        ch_mask_i   = 8'h02;
        t = 0;
        while (res1_cnt < 1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chan_val[1] = 12'd800;
        chk("t6_first_res1", res1_cnt, 1);
        rd_ch_i = 3'd1;
        repeat (2) @(negedge clk);
        chk("t6_table_first", rd_data_o, 400);
        t = 0;
        while (res1_cnt < 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("t6_res_data_raw", last_res1_data, 800);
`ifdef ADC_SCHED_AVG_EN
        chk("t6_table_second", rd_data_o, 500);
`else
        chk("t6_table_second", rd_data_o, 800);
`endif
        scan_en_i = 1'b0;
        wait_idle("t6_idle");

        chk("end_timeouts", tmo_cnt, 1);
        chk("end_res_drained", res_q.size(), 0);
        chk("end_rsp_drained", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
